// File: rtl/matrix_tile_lsu_pkg.sv
// Shared types and constants for the matrix tile load/store unit.
package matrix_tile_lsu_pkg;

  localparam int ROWS     = 4;
  localparam int ELEM_W   = 8;
  localparam int ADDR_W   = 32;
  localparam int ROW_W    = ROWS * ELEM_W;
  localparam int TILE_W   = ROWS * ROW_W;
  localparam int SHADOW_W = (ROWS - 1) * ROW_W;
  localparam int ROW_CNT_W = 2;

  localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(ROWS - 1);

  localparam logic OP_MLD = 1'b0;
  localparam logic OP_MST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
  } state_e;

  // Row i of a tile occupies bits [i*32+31 : i*32].
  function automatic logic [ROW_W-1:0] tile_row(input logic [TILE_W-1:0] tile,
                                                input logic [ROW_CNT_W-1:0] row);
    logic [ROW_W-1:0] r;
    case (row)
      2'd0:    r = tile[0*ROW_W +: ROW_W];
      2'd1:    r = tile[1*ROW_W +: ROW_W];
      2'd2:    r = tile[2*ROW_W +: ROW_W];
      default: r = tile[3*ROW_W +: ROW_W];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/matrix_tile_lsu_row_addr_gen.sv
// Row address generator: base + row*stride (wraps modulo 2^32) and alignment check.
module mat_row_addr_gen
  import matrix_tile_lsu_pkg::*;
(
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W-1:0]    stride,
  input  logic [ROW_CNT_W-1:0] row,
  output logic [ADDR_W-1:0]    addr,
  output logic                 misalign
);

  assign addr     = base + stride * ADDR_W'(row);
  assign misalign = (base[1:0] != 2'b00) || (stride[1:0] != 2'b00);

endmodule

// File: rtl/matrix_tile_lsu.sv
// Matrix tile LSU: moves one 4x4 int8 tile between memory and the matrix datapath,
// one 32-bit row word per bus transfer, with at most one outstanding access.
module matrix_tile_lsu
  import matrix_tile_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_stride,
  input  logic [TILE_W-1:0] st_tile,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ROW_W-1:0]  mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [ROW_W-1:0]  mem_rdata,
  output logic [TILE_W-1:0] ld_tile,
  output logic              done,
  output logic              err,
  output logic              busy
);

  state_e                 state_q, state_d;
  logic [ROW_CNT_W-1:0]   row_q, row_d;
  logic                   op_q, op_d;
  logic                   err_q, err_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [ADDR_W-1:0]      stride_q, stride_d;
  logic [TILE_W-1:0]      st_tile_q, st_tile_d;
  logic [TILE_W-1:0]      ld_tile_q, ld_tile_d;
  logic [SHADOW_W-1:0]    shadow_q, shadow_d;

  logic [ADDR_W-1:0]      gen_base, gen_stride, row_addr;
  logic                   misalign, accept, last_row;

  // In IDLE the generator looks at the incoming request so misalignment is known at acceptance.
  assign gen_base   = (state_q == ST_IDLE) ? req_addr   : base_q;
  assign gen_stride = (state_q == ST_IDLE) ? req_stride : stride_q;
  assign accept     = (state_q == ST_IDLE) && req_valid;
  assign last_row   = (row_q == LAST_ROW);

  mat_row_addr_gen u_addr_gen (
    .base     (gen_base),
    .stride   (gen_stride),
    .row      (row_q),
    .addr     (row_addr),
    .misalign (misalign)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      op_q      <= OP_MLD;
      err_q     <= 1'b0;
      base_q    <= '0;
      stride_q  <= '0;
      st_tile_q <= '0;
      ld_tile_q <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      op_q      <= op_d;
      err_q     <= err_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      st_tile_q <= st_tile_d;
      ld_tile_q <= ld_tile_d;
      shadow_q  <= shadow_d;
    end
  end

  // Next-state logic: misaligned requests skip the bus and go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = misalign ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (mem_gnt) begin
          if (op_q == OP_MLD)  state_d = ST_WAIT_R;
          else if (last_row)   state_d = ST_DONE;
          else                 state_d = ST_REQ;
        end
      end
      ST_WAIT_R: if (mem_rvalid) state_d = last_row ? ST_DONE : ST_REQ;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: capture the request, advance rows, and publish the loaded tile in one step.
  always_comb begin
    row_d     = row_q;
    op_d      = op_q;
    err_d     = err_q;
    base_d    = base_q;
    stride_d  = stride_q;
    st_tile_d = st_tile_q;
    ld_tile_d = ld_tile_q;
    shadow_d  = shadow_q;
    if (accept) begin
      row_d     = '0;
      op_d      = req_op;
      err_d     = misalign;
      base_d    = req_addr;
      stride_d  = req_stride;
      st_tile_d = st_tile;
    end else if ((state_q == ST_REQ) && mem_gnt && (op_q == OP_MST)) begin
      row_d = row_q + 1'b1;
    end else if ((state_q == ST_WAIT_R) && mem_rvalid) begin
      row_d = row_q + 1'b1;
      case (row_q)
        2'd0:    shadow_d[0*ROW_W +: ROW_W] = mem_rdata;
        2'd1:    shadow_d[1*ROW_W +: ROW_W] = mem_rdata;
        2'd2:    shadow_d[2*ROW_W +: ROW_W] = mem_rdata;
        default: ld_tile_d = {mem_rdata, shadow_q};
      endcase
    end
  end

  // Output decode from the current state and captured request.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    mem_req   = (state_q == ST_REQ);
    mem_we    = (state_q == ST_REQ) && (op_q == OP_MST);
    mem_addr  = (state_q == ST_REQ) ? row_addr : '0;
    mem_wdata = ((state_q == ST_REQ) && (op_q == OP_MST)) ? tile_row(st_tile_q, row_q) : '0;
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_DONE) && err_q;
    ld_tile   = ld_tile_q;
  end

endmodule

// File: tb/tb_matrix_tile_lsu.sv
// Self-checking bench for matrix_tile_lsu with a simple bus responder and access scoreboard.
module tb_matrix_tile_lsu;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } acc_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid, req_op;
  logic         req_ready;
  logic [31:0]  req_addr, req_stride;
  logic [127:0] st_tile;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;
  logic [127:0] ld_tile;
  logic         done, err, busy;

  int n_checks = 0;
  int n_fail = 0;

  acc_t        exp_q[$];
  acc_t        obs_q[$];
  logic [31:0] rdata_q[$];
  logic [31:0] stall_addr[$];
  logic [31:0] stall_wdata[$];

  int rv_lat = 1;
  int deny_idx = -1;
  int deny_left = 0;
  int acc_idx = 0;
  int rd_cnt = 0;
  int req_seen = 0;
  bit stray_rv = 0;
  logic [127:0] exp_ld = '0;

  always #5 clk = ~clk;

  matrix_tile_lsu dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_stride(req_stride), .st_tile(st_tile),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_tile(ld_tile), .done(done), .err(err), .busy(busy)
  );

  // Bus responder: grants (optionally after a stall), records accesses, returns read data.
  always @(negedge clk) begin
    if (!rstn) begin
      rd_cnt     = 0;
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEADBEEF;
        end
      end
      if (stray_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        stray_rv   = 0;
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        req_seen++;
        if (acc_idx == deny_idx && deny_left > 0) begin
          deny_left--;
          stall_addr.push_back(mem_addr);
          stall_wdata.push_back(mem_wdata);
        end else begin
          mem_gnt = 1'b1;
          acc_idx++;
          obs_q.push_back('{addr: mem_addr, we: mem_we, data: mem_wdata});
          if (!mem_we) rd_cnt = rv_lat;
        end
      end
    end
  end

  // Drives one request and waits (bounded) for done; reports timing relative to the accept edge.
  task automatic run_op(input logic op, input logic [31:0] addr, input logic [31:0] stride,
                        input logic [127:0] tile, output int done_cyc, output bit err_seen,
                        output bit early, output bit ready_busy, output bit pulse_long,
                        output logic [127:0] ld_done);
    logic [127:0] old_ld;
    @(negedge clk); #1;
    req_seen = 0; acc_idx = 0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_stride = stride; st_tile = tile;
    @(posedge clk); #1;
    req_valid = 1'b0; st_tile = ~tile; req_addr = ~addr; req_stride = ~stride;
    old_ld = ld_tile;
    done_cyc = -1; err_seen = 0; early = 0; ready_busy = 0; ld_done = ld_tile;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc = k; err_seen = err; ld_done = ld_tile;
        break;
      end
      if (ld_tile !== old_ld) early = 1;
      if (req_ready !== 1'b0 || busy !== 1'b1) ready_busy = 1;
    end
    @(negedge clk);
    pulse_long = (done === 1'b1);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_req: got req=%b we=%b expected 0 0", mem_req, mem_we);
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_bus: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if (ld_tile !== 128'h0) begin
      n_fail++; $display("[TB] FAIL reset_ld: got %h expected 0", ld_tile);
    end
    n_checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_flags: got done=%b err=%b busy=%b ready=%b expected 0 0 0 1",
                         done, err, busy, req_ready);
    end
    rstn = 1'b1;
    exp_ld = '0;
  endtask

  task automatic test_mst_basic();
    int dc; bit es, ea, rb, pl; logic [127:0] ld;
    logic [127:0] tile = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    logic [31:0] data_tab [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    deny_idx = -1; obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'h100 + 32'(i) * 32'h10, we: 1'b1, data: data_tab[i]});
    run_op(1'b1, 32'h100, 32'h10, tile, dc, es, ea, rb, pl, ld);
    n_checks++;
    if (dc != 5 || es !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mst_latency: got done_cycle=%0d err=%b expected 5 0", dc, es);
    end
    n_checks++;
    if (ld !== exp_ld || ea) begin
      n_fail++; $display("[TB] FAIL mst_ld_tile: got %h expected %h (unchanged)", ld, exp_ld);
    end
    n_checks++;
    if (rb || pl) begin
      n_fail++; $display("[TB] FAIL mst_busy_ready: got ready_or_idle_while_busy=%b long_done=%b expected 0 0", rb, pl);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL mst_count: got %0d accesses expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      acc_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.addr !== e.addr || o.we !== e.we || o.data !== e.data) begin
        n_fail++; $display("[TB] FAIL mst_access: got %h/%b/%h expected %h/%b/%h", o.addr, o.we, o.data, e.addr, e.we, e.data);
      end
    end
  endtask

  task automatic test_mld_basic();
    int dc; bit es, ea, rb, pl; logic [127:0] ld;
    deny_idx = -1; rv_lat = 3; obs_q.delete(); exp_q.delete(); rdata_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{addr: 32'h200 + 32'(i) * 32'h4, we: 1'b0, data: 32'h0});
      rdata_q.push_back(32'h11111111 * 32'(i + 1));
    end
    run_op(1'b0, 32'h200, 32'h4, 128'h0, dc, es, ea, rb, pl, ld);
    exp_ld = 128'h44444444_33333333_22222222_11111111;
    n_checks++;
    if (dc != 17 || es !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mld_latency: got done_cycle=%0d err=%b expected 17 0", dc, es);
    end
    n_checks++;
    if (ld !== exp_ld) begin
      n_fail++; $display("[TB] FAIL mld_tile: got %h expected %h", ld, exp_ld);
    end
    n_checks++;
    if (ea) begin
      n_fail++; $display("[TB] FAIL mld_atomic: got ld_tile change before done expected none");
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL mld_count: got %0d accesses expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      acc_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.addr !== e.addr || o.we !== e.we) begin
        n_fail++; $display("[TB] FAIL mld_access: got %h/%b expected %h/%b", o.addr, o.we, e.addr, e.we);
      end
    end
  endtask

  task automatic test_mld_wrap();
    int dc; bit es, ea, rb, pl; logic [127:0] ld;
    logic [31:0] addr_tab [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    logic [31:0] r;
    deny_idx = -1; rv_lat = 1; obs_q.delete(); exp_q.delete(); rdata_q.delete();
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      exp_q.push_back('{addr: addr_tab[i], we: 1'b0, data: 32'h0});
      rdata_q.push_back(r);
      exp_ld[i*32 +: 32] = r;
    end
    run_op(1'b0, 32'hFFFFFFF8, 32'h4, 128'h0, dc, es, ea, rb, pl, ld);
    n_checks++;
    if (dc != 9 || ld !== exp_ld) begin
      n_fail++; $display("[TB] FAIL wrap_done: got cycle=%0d tile=%h expected 9 %h", dc, ld, exp_ld);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL wrap_count: got %0d accesses expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      acc_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.addr !== e.addr || o.we !== e.we) begin
        n_fail++; $display("[TB] FAIL wrap_access: got %h/%b expected %h/%b", o.addr, o.we, e.addr, e.we);
      end
    end
  endtask

  task automatic test_misaligned();
    int dc; bit es, ea, rb, pl; logic [127:0] ld;
    logic [31:0] addr_tab [2]   = '{32'h102, 32'h100};
    logic [31:0] stride_tab [2] = '{32'h4, 32'h6};
    for (int i = 0; i < 2; i++) begin
      deny_idx = -1; obs_q.delete();
      run_op(i[0], addr_tab[i], stride_tab[i], 128'h1234, dc, es, ea, rb, pl, ld);
      n_checks++;
      if (dc != 1 || es !== 1'b1) begin
        n_fail++; $display("[TB] FAIL misalign_done_%0d: got cycle=%0d err=%b expected 1 1", i, dc, es);
      end
      n_checks++;
      if (req_seen != 0 || obs_q.size() != 0 || ld !== exp_ld) begin
        n_fail++; $display("[TB] FAIL misalign_nobus_%0d: got req_cycles=%0d tile=%h expected 0 %h", i, req_seen, ld, exp_ld);
      end
    end
  endtask

  task automatic test_stall_and_reset();
    bit saw_done = 0;
    logic [127:0] tile = {$urandom, $urandom, $urandom, $urandom};
    obs_q.delete(); exp_q.delete(); stall_addr.delete(); stall_wdata.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{addr: 32'h300 + 32'(i) * 32'h20, we: 1'b1, data: tile[i*32 +: 32]});
    @(negedge clk); #1;
    acc_idx = 0; deny_idx = 1; deny_left = 5;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 32'h300; req_stride = 32'h20; st_tile = tile;
    @(posedge clk); #1;
    req_valid = 1'b0; st_tile = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done === 1'b1) saw_done = 1;
      if (acc_idx >= 2) break;
    end
    @(negedge clk); #1;
    rstn = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_state: got req=%b busy=%b ready=%b done=%b expected 0 0 1 0", mem_req, busy, req_ready, done);
    end
    rstn = 1'b1;
    exp_ld = '0;
    stray_rv = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1 || mem_req === 1'b1) saw_done = 1;
    end
    n_checks++;
    if (saw_done || ld_tile !== exp_ld) begin
      n_fail++; $display("[TB] FAIL abort_quiet: got spurious_activity=%b tile=%h expected 0 %h", saw_done, ld_tile, exp_ld);
    end
    n_checks++;
    if (stall_addr.size() != 5) begin
      n_fail++; $display("[TB] FAIL stall_count: got %0d stalled cycles expected 5", stall_addr.size());
    end
    while (stall_addr.size() > 0) begin
      logic [31:0] sa, sd;
      sa = stall_addr.pop_front(); sd = stall_wdata.pop_front();
      n_checks++;
      if (sa !== 32'h320 || sd !== tile[63:32]) begin
        n_fail++; $display("[TB] FAIL stall_stable: got %h/%h expected %h/%h", sa, sd, 32'h320, tile[63:32]);
      end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL abort_count: got %0d accesses expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      acc_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.addr !== e.addr || o.we !== e.we || o.data !== e.data) begin
        n_fail++; $display("[TB] FAIL abort_access: got %h/%b/%h expected %h/%b/%h", o.addr, o.we, o.data, e.addr, e.we, e.data);
      end
    end
    deny_idx = -1;
  endtask

  task automatic test_back_to_back();
    int dc; bit es, ea, rb, pl; logic [127:0] ld;
    logic [127:0] tile = {$urandom, $urandom, $urandom, $urandom};
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('{addr: 32'h0 + 32'(i) * 32'h0, we: 1'b1, data: tile[i*32 +: 32]});
    run_op(1'b1, 32'h0, 32'h0, tile, dc, es, ea, rb, pl, ld);
    n_checks++;
    if (dc != 5 || es !== 1'b0 || rb || pl || ld !== exp_ld) begin
      n_fail++; $display("[TB] FAIL b2b_done: got cycle=%0d err=%b rb=%b long=%b tile=%h expected 5 0 0 0 %h", dc, es, rb, pl, ld, exp_ld);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("[TB] FAIL b2b_count: got %0d accesses expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      acc_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.addr !== e.addr || o.we !== e.we || o.data !== e.data) begin
        n_fail++; $display("[TB] FAIL b2b_access: got %h/%b/%h expected %h/%b/%h", o.addr, o.we, o.data, e.addr, e.we, e.data);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_op = 1'b0;
    req_addr = '0; req_stride = '0; st_tile = '0;
    test_reset();
    test_mst_basic();
    test_mld_basic();
    test_mld_wrap();
    test_misaligned();
    test_stall_and_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
